// File: rtl/bitplane_collector.sv
// Bit-serial to parallel collector: gathers WIDTH bit-planes (LSB first) across
// LANES lanes and presents each completed frame on a valid/ready output register.
module bitplane_collector #(
  parameter int LANES = 64,
  parameter int WIDTH = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic                       plane_valid,
  input  logic [LANES-1:0]           plane,
  input  logic                       out_ready,
  output logic                       out_valid,
  output logic [LANES*WIDTH-1:0]     X,
  output logic                       busy,
  output logic [$clog2(WIDTH):0]     bit_count,
  output logic                       overrun
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic {IDLE, COLLECT} state_t;

  state_t                        state_q, state_d;
  logic [CW-1:0]                 cnt_q, cnt_d;
  logic [LANES-1:0][WIDTH-1:0]   shadow_q, shadow_d;
  logic [LANES-1:0][WIDTH-1:0]   out_reg_q, out_reg_d;
  logic                          out_valid_q, out_valid_d;
  logic                          overrun_q, overrun_d;

  logic [LANES-1:0][WIDTH-1:0]   shifted;
  logic                          accept;
  logic                          last_bit;
  logic                          complete;

  // New bit enters at the MSB; written generically so WIDTH=1 needs no special slice.
  function automatic logic [WIDTH-1:0] shift_in(input logic b, input logic [WIDTH-1:0] w);
    logic [WIDTH:0] t;
    t = {b, w} >> 1;
    return t[WIDTH-1:0];
  endfunction

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    shadow_d    = shadow_q;
    out_reg_d   = out_reg_q;
    out_valid_d = out_valid_q;
    overrun_d   = overrun_q;

    for (int k = 0; k < LANES; k++) begin
      shifted[k] = shift_in(plane[k], shadow_q[k]);
    end

    accept   = plane_valid && ((state_q == COLLECT) || start);
    // In COLLECT the completion check wins over a coincident start.
    last_bit = (state_q == COLLECT) ? (cnt_q == CW'(WIDTH - 1)) : (WIDTH == 1);
    complete = accept && last_bit;

    if (accept) begin
      shadow_d = shifted;
    end

    if (complete) begin
      if (!out_valid_q || out_ready) begin
        out_reg_d   = shifted;
        out_valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
      state_d = start ? COLLECT : IDLE;
      cnt_d   = '0;
    end else begin
      if (out_valid_q && out_ready) begin
        out_valid_d = 1'b0;
      end
      if (start) begin
        state_d = COLLECT;
        cnt_d   = plane_valid ? CW'(1) : '0;
      end else if (accept) begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      shadow_q    <= '0;
      out_reg_q   <= '0;
      out_valid_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      shadow_q    <= shadow_d;
      out_reg_q   <= out_reg_d;
      out_valid_q <= out_valid_d;
      overrun_q   <= overrun_d;
    end
  end

  assign X         = out_reg_q;
  assign out_valid = out_valid_q;
  assign busy      = (state_q == COLLECT);
  assign bit_count = cnt_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_bitplane_collector.sv
// Bench for bitplane_collector: directed scenarios plus randomized traffic, all
// checked every cycle against a word-level reference model.
module tb_bitplane_collector;

  localparam int LANES = 64;
  localparam int WIDTH = 16;
  localparam int TW    = LANES * WIDTH;

  logic                   clk = 1'b0;
  logic                   reset;
  logic                   start;
  logic                   plane_valid;
  logic [LANES-1:0]       plane;
  logic                   out_ready;
  logic                   out_valid;
  logic [TW-1:0]          X;
  logic                   busy;
  logic [$clog2(WIDTH):0] bit_count;
  logic                   overrun;

  bitplane_collector #(.LANES(LANES), .WIDTH(WIDTH)) dut (
    .clk(clk), .reset(reset), .start(start), .plane_valid(plane_valid),
    .plane(plane), .out_ready(out_ready), .out_valid(out_valid), .X(X),
    .busy(busy), .bit_count(bit_count), .overrun(overrun)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  // Reference model: words built by bit position, frame-level bookkeeping.
  logic [15:0]   m_words [LANES];
  logic [TW-1:0] m_out;
  bit            m_coll, m_ov, m_overrun;
  int            m_cnt;

  logic [15:0]   fw [LANES];

  task automatic check(input string tag, input logic [TW-1:0] obs, input logic [TW-1:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic model_clear();
    for (int k = 0; k < LANES; k++) m_words[k] = '0;
    m_out = '0; m_coll = 0; m_ov = 0; m_overrun = 0; m_cnt = 0;
  endtask

  task automatic model_step(input logic s, input logic pv, input logic [LANES-1:0] pl, input logic rdy);
    bit acc, comp;
    int idx;
    acc  = pv && (m_coll || s);
    idx  = (!m_coll || (s && m_cnt != WIDTH - 1)) ? 0 : m_cnt;
    comp = acc && (idx == WIDTH - 1);
    if (acc) begin
      for (int k = 0; k < LANES; k++) begin
        if (idx == 0) m_words[k] = '0;
        m_words[k][idx] = pl[k];
      end
    end
    if (comp) begin
      if (!m_ov || rdy) begin
        for (int k = 0; k < LANES; k++) m_out[16*k +: 16] = m_words[k];
        m_ov = 1;
      end else begin
        m_overrun = 1;
      end
      m_coll = s;
      m_cnt  = 0;
    end else begin
      if (m_ov && rdy) m_ov = 0;
      if (s) begin
        m_coll = 1;
        m_cnt  = pv ? 1 : 0;
      end else if (acc) begin
        m_cnt++;
      end
    end
  endtask

  task automatic compare_all();
    check("m_out_valid", TW'(out_valid), TW'(m_ov));
    check("m_x",         X,              m_out);
    check("m_busy",      TW'(busy),      TW'(m_coll));
    check("m_bit_count", TW'(bit_count), TW'(m_cnt));
    check("m_overrun",   TW'(overrun),   TW'(m_overrun));
  endtask

  task automatic cycle(input logic s, input logic pv, input logic [LANES-1:0] pl, input logic rdy);
    start = s; plane_valid = pv; plane = pl; out_ready = rdy;
    model_step(s, pv, pl, rdy);
    @(posedge clk); #1;
    compare_all();
  endtask

  task automatic do_reset();
    reset = 1'b1; start = 1'b0; plane_valid = 1'b0; out_ready = 1'b0;
    plane = {$urandom, $urandom};
    @(posedge clk); #1;
    reset = 1'b0;
    model_clear();
    compare_all();
  endtask

  task automatic set_all(input logic [15:0] v);
    for (int k = 0; k < LANES; k++) fw[k] = v;
  endtask

  // Sends np planes of fw with start on the first; optional 3-cycle gaps.
  task automatic send(input int np, input int gap_a, input int gap_b, input logic rdy_last);
    logic [LANES-1:0] pl;
    for (int p = 0; p < np; p++) begin
      for (int k = 0; k < LANES; k++) pl[k] = fw[k][p];
      cycle(p == 0, 1'b1, pl, (p == WIDTH - 1) ? rdy_last : 1'b0);
      if (p == gap_a || p == gap_b) begin
        for (int g = 0; g < 3; g++) begin
          cycle(1'b0, 1'b0, {$urandom, $urandom}, 1'b0);
          check("gap_bit_count", TW'(bit_count), TW'(p + 1));
        end
      end
    end
  endtask

  task automatic check_tp1(input string tag);
    check({tag, "_valid"}, TW'(out_valid), TW'(1));
    check({tag, "_busy"},  TW'(busy),      TW'(0));
    check({tag, "_x0"},    TW'(X[15:0]),       TW'(16'h0001));
    check({tag, "_x5"},    TW'(X[16*5 +: 16]), TW'(16'hA5A5));
    check({tag, "_x63"},   TW'(X[16*63 +: 16]), TW'(16'h8000));
    check({tag, "_xall"},  X, {16'h8000, {57{16'h0000}}, 16'hA5A5, {4{16'h0000}}, 16'h0001});
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; plane_valid = 1'b0; plane = '0; out_ready = 1'b0;
    model_clear();
    repeat (2) @(posedge clk);
    do_reset();
    check("rst_x",         X,              '0);
    check("rst_out_valid", TW'(out_valid), TW'(0));
    check("rst_busy",      TW'(busy),      TW'(0));
    check("rst_bit_count", TW'(bit_count), TW'(0));
    check("rst_overrun",   TW'(overrun),   TW'(0));

    // Single frame
    set_all(16'h0000); fw[0] = 16'h0001; fw[5] = 16'hA5A5; fw[63] = 16'h8000;
    send(16, -1, -1, 1'b0);
    check_tp1("tp1");
    cycle(1'b0, 1'b0, '0, 1'b1);
    check("tp1_ack", TW'(out_valid), TW'(0));

    // Gapped frame
    send(16, 2, 9, 1'b0);
    check_tp1("tp2");
    cycle(1'b0, 1'b0, '0, 1'b1);

    // Backpressure and overrun
    set_all(16'h1234); send(16, -1, -1, 1'b0);
    set_all(16'hFFFF); send(16, -1, -1, 1'b0);
    check("tp3_x",       X,              {LANES{16'h1234}});
    check("tp3_overrun", TW'(overrun),   TW'(1));
    check("tp3_valid",   TW'(out_valid), TW'(1));
    cycle(1'b0, 1'b0, '0, 1'b1);
    check("tp3_ack_valid",   TW'(out_valid), TW'(0));
    check("tp3_ack_overrun", TW'(overrun),   TW'(1));
    check("tp3_ack_x",       X,              {LANES{16'h1234}});

    // Ack coincident with completion
    do_reset();
    set_all(16'h1111); send(16, -1, -1, 1'b0);
    set_all(16'h2222); send(16, -1, -1, 1'b1);
    check("tp4_valid",   TW'(out_valid), TW'(1));
    check("tp4_x",       X,              {LANES{16'h2222}});
    check("tp4_overrun", TW'(overrun),   TW'(0));
    cycle(1'b0, 1'b0, '0, 1'b1);

    // Restart mid-frame
    set_all(16'hFFFF); send(7, -1, -1, 1'b0);
    set_all(16'h00F0); send(16, -1, -1, 1'b0);
    check("tp5_x", X, {LANES{16'h00F0}});

    // Reset mid-frame with output pending
    set_all(16'hFFFF); send(5, -1, -1, 1'b0);
    do_reset();
    check("tp5_rst_busy",  TW'(busy),      TW'(0));
    check("tp5_rst_bc",    TW'(bit_count), TW'(0));
    check("tp5_rst_valid", TW'(out_valid), TW'(0));
    set_all(16'h0F0F); send(16, -1, -1, 1'b0);
    check("tp5_x2",     X,              {LANES{16'h0F0F}});
    check("tp5_valid2", TW'(out_valid), TW'(1));

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 499) == 0) do_reset();
      else cycle($urandom_range(0, 19) == 0, $urandom_range(0, 3) != 0,
                 {$urandom, $urandom}, $urandom_range(0, 1) == 1);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
